// File: rtl/count_uart_tx_if.sv
// Sample handshake and serial-status bundle between the counter stage and count_uart_tx.
interface count_uart_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] frames_sent;

    modport master (
        output in_data, in_valid,
        input  in_ready, tx, busy, done, frames_sent
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, tx, busy, done, frames_sent
    );
endinterface

// File: rtl/count_uart_tx.sv
// Serialises 8-bit counter samples into start/data/[parity]/stop frames on tx, LSB first.
// Optional even parity bit after D7 is compiled in with `define COUNT_UART_TX_PARITY_EN.
module count_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input logic            clk,
    input logic            rst_n,
    count_uart_tx_if.slave bus
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2);

`ifdef COUNT_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic [7:0]  frames_q, frames_d;
`ifdef COUNT_UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic expire;
    assign expire = (timer_q == 16'd0);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        frames_d   = frames_q;
`ifdef COUNT_UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q != IDLE) begin
            timer_d = expire ? BIT_LAST : (timer_q - 16'd1);
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = START;
                    timer_d = BIT_LAST;
                    shift_d = bus.in_data;
`ifdef COUNT_UART_TX_PARITY_EN
                    parity_d = ^bus.in_data;
`endif
                end
            end
            START: begin
                if (expire) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef COUNT_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
`endif
                    end
                end
            end
`ifdef COUNT_UART_TX_PARITY_EN
            PARITY: begin
                if (expire) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            STOP: begin
                // Only a fully completed stop period counts as a sent frame.
                if (expire) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        frames_d = frames_q + 8'd1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next-state view so the pin changes on the same edge as the state.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef COUNT_UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= 16'd0;
            idx_q      <= 3'd0;
            stop_idx_q <= 1'b0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            frames_q   <= 8'd0;
`ifdef COUNT_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            frames_q   <= frames_d;
`ifdef COUNT_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.tx          = tx_q;
    assign bus.done        = done_q;
    assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx: two instances (4 clk/bit 1 stop, 2 clk/bit 2 stop) with a per-cycle tx scoreboard.
module tb_count_uart_tx;

    localparam int CPB_A = 4;
    localparam int SB_A  = 1;
    localparam int CPB_B = 2;
    localparam int SB_B  = 2;
`ifdef COUNT_UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    count_uart_tx_if ifa ();
    count_uart_tx_if ifb ();

    count_uart_tx #(.CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    count_uart_tx #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    int   checks = 0;
    int   errors = 0;
    int   fa = 0;
    int   fb = 0;
    logic exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cpb(input int d);
        return (d == 0) ? CPB_A : CPB_B;
    endfunction

    function automatic int flen(input int d);
        return (1 + 8 + P + ((d == 0) ? SB_A : SB_B)) * cpb(d);
    endfunction

    function automatic logic [11:0] status(input int d);
        if (d == 0) return {ifa.tx, ifa.busy, ifa.in_ready, ifa.done, ifa.frames_sent};
        else        return {ifb.tx, ifb.busy, ifb.in_ready, ifb.done, ifb.frames_sent};
    endfunction

    task automatic set_in(input int d, input logic [7:0] data, input logic v);
        if (d == 0) begin ifa.in_data = data; ifa.in_valid = v; end
        else        begin ifb.in_data = data; ifb.in_valid = v; end
    endtask

    task automatic expect_frame(input int d, input logic [7:0] data);
        int sb;
        sb = (d == 0) ? SB_A : SB_B;
        for (int i = 0; i < cpb(d); i++) exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < cpb(d); i++) exp_q.push_back(data[b]);
        if (P == 1)
            for (int i = 0; i < cpb(d); i++) exp_q.push_back(^data);
        for (int i = 0; i < sb * cpb(d); i++) exp_q.push_back(1'b1);
    endtask

    // Present a sample; the handshake edge is the next rising edge.
    task automatic send(input int d, input logic [7:0] data, input logic hold, input logic [7:0] during);
        set_in(d, data, 1'b1);
        expect_frame(d, data);
        @(posedge clk); #1;
        set_in(d, during, hold);
    endtask

    // Entered at #1 after the handshake edge; returns in the done cycle.
    task automatic check_frame(input int d, input string tag);
        logic [11:0] s;
        logic        e;
        for (int k = 0; k < flen(d); k++) begin
            s = status(d);
            if (exp_q.size() == 0) e = 1'b1;
            else e = exp_q.pop_front();
            chk({tag, "_tx"}, {31'd0, s[11]}, {31'd0, e});
            chk({tag, "_busy_rdy_done"}, {29'd0, s[10:8]}, {29'd0, 3'b100});
            @(posedge clk); #1;
        end
        if (d == 0) fa++; else fb++;
        s = status(d);
        chk({tag, "_end_tx_busy_rdy_done"}, {28'd0, s[11:8]}, {28'd0, 4'b1011});
        chk({tag, "_frames"}, {24'd0, s[7:0]}, (d == 0) ? 32'(fa[7:0]) : 32'(fb[7:0]));
    endtask

    initial begin
        logic [11:0] s;
        set_in(0, 8'h00, 1'b0);
        set_in(1, 8'h00, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", {20'd0, status(0)}, {20'd0, 12'hA00});
        chk("rst_b", {20'd0, status(1)}, {20'd0, 12'hA00});
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_a", {20'd0, status(0)}, {20'd0, 12'hA00});

        // Reset abort during D3
        send(0, 8'hA5, 1'b0, 8'h00);
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_pre_busy", {31'd0, ifa.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_state", {20'd0, status(0)}, {20'd0, 12'hA00});
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {31'd0, ifa.done}, 32'd0);
        end
        chk("abort_frames", {24'd0, ifa.frames_sent}, 32'd0);

        // Single frames (parity values differ only in the parity build)
        send(0, 8'hA5, 1'b0, 8'h00);
        check_frame(0, "a5");
        @(posedge clk); #1;
        chk("a5_done_pulse", {31'd0, ifa.done}, 32'd0);
        send(0, 8'h07, 1'b0, 8'h00);
        check_frame(0, "f07");
        send(0, 8'h03, 1'b0, 8'h00);
        check_frame(0, "f03");

        // Back-to-back with in_valid held; mid-frame data must be ignored
        send(0, 8'h01, 1'b1, 8'h55);
        check_frame(0, "b2b1");
        set_in(0, 8'h02, 1'b1);
        expect_frame(0, 8'h02);
        @(posedge clk); #1;
        set_in(0, 8'h00, 1'b0);
        check_frame(0, "b2b2");

        // Two stop bits, 2 clocks per bit
        send(1, 8'h3C, 1'b0, 8'h00);
        check_frame(1, "sb2");

        // Counter wrap through 255 -> 0
        for (int n = 0; n < 256; n++) begin
            send(1, 8'(n), 1'b0, 8'h00);
            check_frame(1, "wrap");
        end
        s = status(1);
        chk("wrap_final_frames", {24'd0, s[7:0]}, 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
